// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared pipeline package: base opcode defines used by the decode stage,
//   plus the instruction-memory loader FSM encoding and stream field widths.
//   No ports (package).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  // Major opcodes (instr[6:0]) shared with the decode stage.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Loader stream field widths.
  localparam int LDR_LEN_W      = 16;  // word count N / word index
  localparam int LDR_CHK_W      = 8;   // XOR checksum
  localparam int LDR_BYTE_CNT_W = 2;   // byte position inside a word

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_HI = 3'd1,
    LDR_LEN_LO = 3'd2,
    LDR_WORD   = 3'd3,
    LDR_CHK    = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERR    = 3'd6
  } ldr_state_e;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] ldr_word_addr(input logic [31:0]          base,
                                                input logic [LDR_LEN_W-1:0] idx);
    return base + {{(32-LDR_LEN_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a byte stream (2-byte big-endian word count N, N big-endian
//   32-bit words, 1 XOR checksum byte), writes each word into instruction
//   memory and holds the CPU in reset until a complete, checksum-correct
//   image has been loaded.
//
// Ports
//   clk                  in   clock, rising edge
//   reset                in   asynchronous active-high reset
//   start_ldr_i          in   pulse: begin (or restart) a load session
//   byte_valid_ldr_i     in   byte offered on byte_data_ldr_i
//   byte_data_ldr_i[7:0] in   stream byte
//   byte_ready_ldr_o     out  loader accepts a byte this cycle
//   wr_en_imem_ldr_o     out  imem write strobe (one cycle per word)
//   wr_addr_imem_ldr_o   out  imem byte address
//   wr_instr_imem_ldr_o  out  imem write data
//   cpu_reset_ldr_o      out  pipeline held in reset while high
//   done_ldr_o           out  image loaded, checksum good
//   err_ldr_o            out  load failed (length or checksum)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_ldr_i,
  input  logic        byte_valid_ldr_i,
  input  logic [7:0]  byte_data_ldr_i,
  output logic        byte_ready_ldr_o,
  output logic        wr_en_imem_ldr_o,
  output logic [31:0] wr_addr_imem_ldr_o,
  output logic [31:0] wr_instr_imem_ldr_o,
  output logic        cpu_reset_ldr_o,
  output logic        done_ldr_o,
  output logic        err_ldr_o
);

  localparam logic [31:0] LP_MAX_WORDS = 32'(IMEM_WORDS);

  ldr_state_e                r_state;
  ldr_state_e                w_state_nxt;
  logic [LDR_LEN_W-1:0]      r_len;
  logic [LDR_LEN_W-1:0]      r_word_idx;
  logic [LDR_BYTE_CNT_W-1:0] r_byte_cnt;
  logic [31:0]               r_asm;
  logic [LDR_CHK_W-1:0]      r_chk;
  logic                      r_wr_en;
  logic [31:0]               r_wr_addr;
  logic [31:0]               r_wr_instr;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_last_byte;
  logic                      w_last_word;
  logic [LDR_LEN_W-1:0]      w_len_full;

  // A start pulse always wins: any byte offered in the same cycle is dropped.
  assign w_accept    = byte_valid_ldr_i && w_ready && !start_ldr_i;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = ((r_word_idx + 16'd1) == r_len);
  // Full count as it will be once the low byte lands this cycle.
  assign w_len_full  = {r_len[15:8], byte_data_ldr_i};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LDR_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_ready         = 1'b0;
    cpu_reset_ldr_o = 1'b1;
    done_ldr_o      = 1'b0;
    err_ldr_o       = 1'b0;

    unique case (r_state)
      LDR_IDLE:   ;
      LDR_LEN_HI: begin
        w_ready = 1'b1;
        if (w_accept) w_state_nxt = LDR_LEN_LO;
      end
      LDR_LEN_LO: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if ({16'd0, w_len_full} > LP_MAX_WORDS) w_state_nxt = LDR_ERR;
          else if (w_len_full == '0)              w_state_nxt = LDR_CHK;
          else                                    w_state_nxt = LDR_WORD;
        end
      end
      LDR_WORD: begin
        w_ready = 1'b1;
        if (w_accept && w_last_byte && w_last_word) w_state_nxt = LDR_CHK;
      end
      LDR_CHK: begin
        w_ready = 1'b1;
        if (w_accept)
          w_state_nxt = (byte_data_ldr_i == r_chk) ? LDR_DONE : LDR_ERR;
      end
      LDR_DONE: begin
        cpu_reset_ldr_o = 1'b0;
        done_ldr_o      = 1'b1;
      end
      LDR_ERR: err_ldr_o = 1'b1;
      default: w_state_nxt = LDR_IDLE;
    endcase

    if (start_ldr_i) w_state_nxt = LDR_LEN_HI;
  end

  assign byte_ready_ldr_o = w_ready;

  // ---------------------------------------------------------------------------
  // Datapath: length, word assembly, checksum, write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_chk      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_instr <= '0;
    end else begin
      r_wr_en <= 1'b0;  // strobe is a single-cycle pulse
      if (start_ldr_i) begin
        r_len      <= '0;
        r_word_idx <= '0;
        r_byte_cnt <= '0;
        r_asm      <= '0;
        r_chk      <= '0;
        r_wr_addr  <= BASE_ADDR;
      end else if (w_accept) begin
        unique case (r_state)
          LDR_LEN_HI: r_len[15:8] <= byte_data_ldr_i;
          LDR_LEN_LO: r_len[7:0]  <= byte_data_ldr_i;
          LDR_WORD: begin
            r_asm      <= {r_asm[23:0], byte_data_ldr_i};
            r_chk      <= r_chk ^ byte_data_ldr_i;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_wr_en    <= 1'b1;
              r_wr_instr <= {r_asm[23:0], byte_data_ldr_i};
              r_wr_addr  <= ldr_word_addr(BASE_ADDR, r_word_idx);
              r_word_idx <= r_word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en_imem_ldr_o    = r_wr_en;
  assign wr_addr_imem_ldr_o  = r_wr_addr;
  assign wr_instr_imem_ldr_o = r_wr_instr;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader (IMEM_WORDS=1024, BASE_ADDR=0).
//   Expected writes and final status come from a stream-level model: parse
//   N, split the word bytes, XOR them, compare with the trailing byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int          IMEM_WORDS = 1024;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;

  typedef logic [7:0]  bq_t [$];
  typedef logic [63:0] wq_t [$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start_ldr_i;
  logic        byte_valid_ldr_i;
  logic [7:0]  byte_data_ldr_i;
  logic        byte_ready_ldr_o;
  logic        wr_en_imem_ldr_o;
  logic [31:0] wr_addr_imem_ldr_o;
  logic [31:0] wr_instr_imem_ldr_o;
  logic        cpu_reset_ldr_o;
  logic        done_ldr_o;
  logic        err_ldr_o;

  int n_checks = 0;
  int n_fails  = 0;
  wq_t obs_w;

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .BASE_ADDR(BASE_ADDR)) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .start_ldr_i         (start_ldr_i),
    .byte_valid_ldr_i    (byte_valid_ldr_i),
    .byte_data_ldr_i     (byte_data_ldr_i),
    .byte_ready_ldr_o    (byte_ready_ldr_o),
    .wr_en_imem_ldr_o    (wr_en_imem_ldr_o),
    .wr_addr_imem_ldr_o  (wr_addr_imem_ldr_o),
    .wr_instr_imem_ldr_o (wr_instr_imem_ldr_o),
    .cpu_reset_ldr_o     (cpu_reset_ldr_o),
    .done_ldr_o          (done_ldr_o),
    .err_ldr_o           (err_ldr_o)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high records one write.
  always @(negedge clk) begin
    if (!reset && wr_en_imem_ldr_o)
      obs_w.push_back({wr_addr_imem_ldr_o, wr_instr_imem_ldr_o});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what a complete session stream must produce.
  function automatic void model(input bq_t s, output wq_t w, output bit d, output bit e);
    int n;
    logic [7:0]  x;
    logic [31:0] word;
    w = {};
    d = 1'b0;
    e = 1'b0;
    n = s[0] * 256 + s[1];
    if (n > IMEM_WORDS) begin
      e = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      word = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
      x    = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
      w.push_back({BASE_ADDR + 32'(4 * i), word});
    end
    if (s[2+4*n] == x) d = 1'b1;
    else               e = 1'b1;
  endfunction

  function automatic bq_t make_stream(input int n, input bit corrupt);
    bq_t s;
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    logic [15:0] nn = 16'(n);
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      s.push_back(b);
    end
    if (corrupt) x = x ^ 8'(1 + $urandom_range(0, 254));
    s.push_back(x);
    return s;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start_ldr_i = 1'b1;
    @(negedge clk);
    start_ldr_i = 1'b0;
  endtask

  // Offer one byte; returns once it has been accepted on a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        byte_valid_ldr_i = 1'b0;
        byte_data_ldr_i  = 8'($urandom);
      end
    end
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      byte_valid_ldr_i = 1'b1;
      byte_data_ldr_i  = b;
      if (byte_ready_ldr_o) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bytes(input bq_t s, input bit gaps);
    foreach (s[i]) send_byte(s[i], gaps);
    @(negedge clk);
    byte_valid_ldr_i = 1'b0;
  endtask

  task automatic verify(input string tag, input wq_t w, input bit d, input bit e);
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, 32'(obs_w.size()), 32'(w.size()));
    for (int i = 0; i < w.size() && i < obs_w.size(); i++) begin
      check({tag, "_addr"}, obs_w[i][63:32], w[i][63:32]);
      check({tag, "_data"}, obs_w[i][31:0],  w[i][31:0]);
    end
    check({tag, "_done"},   32'(done_ldr_o),       32'(d));
    check({tag, "_err"},    32'(err_ldr_o),        32'(e));
    check({tag, "_cpurst"}, 32'(cpu_reset_ldr_o),  32'(!d));
    check({tag, "_ready"},  32'(byte_ready_ldr_o), 32'd0);
  endtask

  task automatic run_session(input string tag, input bq_t s, input bit gaps);
    wq_t w;
    bit d, e;
    model(s, w, d, e);
    obs_w = {};
    pulse_start();
    send_bytes(s, gaps);
    verify(tag, w, d, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(byte_ready_ldr_o), 32'd0);
    check({tag, "_wren"},   32'(wr_en_imem_ldr_o), 32'd0);
    check({tag, "_addr"},   wr_addr_imem_ldr_o,    BASE_ADDR);
    check({tag, "_instr"},  wr_instr_imem_ldr_o,   32'd0);
    check({tag, "_cpurst"}, 32'(cpu_reset_ldr_o),  32'd1);
    check({tag, "_done"},   32'(done_ldr_o),       32'd0);
    check({tag, "_err"},    32'(err_ldr_o),        32'd0);
  endtask

  initial begin
    bq_t s;
    wq_t w;
    bit  d, e;

    reset            = 1'b1;
    start_ldr_i      = 1'b0;
    byte_valid_ldr_i = 1'b0;
    byte_data_ldr_i  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Directed scenarios.
    run_session("one_word", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 1'b0);
    run_session("two_word", '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h2D}, 1'b0);
    run_session("bad_chk",  '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 1'b0);
    run_session("zero_ok",  '{8'h00, 8'h00, 8'h00}, 1'b0);
    run_session("zero_bad", '{8'h00, 8'h00, 8'h01}, 1'b0);

    // N = 1025: error immediately after the second count byte.
    obs_w = {};
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    #1;
    check("too_long_err_now", 32'(err_ldr_o),        32'd1);
    check("too_long_rdy_now", 32'(byte_ready_ldr_o), 32'd0);
    @(negedge clk);
    byte_valid_ldr_i = 1'b0;
    verify("too_long", w, 1'b0, 1'b1);

    // Largest legal image: last write at BASE + 4*1023.
    s = make_stream(IMEM_WORDS, 1'b0);
    run_session("max_len", s, 1'b0);

    // Reset after two word bytes, then a full session (plain and with gaps).
    obs_w = {};
    pulse_start();
    send_bytes('{8'h00, 8'h01, 8'h12, 8'h34}, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_nwr", 32'(obs_w.size()), 32'd0);
    run_session("after_rst",     '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 1'b0);
    run_session("after_rst_gap", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 1'b1);

    // Restart mid-word; the byte offered with the start pulse is discarded.
    obs_w = {};
    pulse_start();
    send_bytes('{8'h00, 8'h02, 8'hAA, 8'hBB}, 1'b0);
    start_ldr_i      = 1'b1;
    byte_valid_ldr_i = 1'b1;
    byte_data_ldr_i  = 8'h55;
    @(negedge clk);
    start_ldr_i      = 1'b0;
    byte_valid_ldr_i = 1'b0;
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    model(s, w, d, e);
    send_bytes(s, 1'b1);
    verify("restart", w, d, e);

    // Randomized sessions.
    for (int k = 0; k < 24; k++) begin
      s = make_stream($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
      run_session($sformatf("rand%0d", k), s, bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_ldr_i  in  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port byte_valid_ldr_i  in  1  a byte is offered on byte_data_ldr_i.
REQ-007 SHALL have port byte_data_ldr_i  in  8  offered stream byte.
REQ-008 SHALL have port byte_ready_ldr_o  out  1  loader can accept a byte this cycle.
REQ-009 SHALL have port wr_en_imem_ldr_o  out  1  instruction memory write strobe.
REQ-010 SHALL have port wr_addr_imem_ldr_o  out  32  instruction memory byte address.
REQ-011 SHALL have port wr_instr_imem_ldr_o  out  32  instruction word to write.
REQ-012 SHALL have port cpu_reset_ldr_o  out  1  holds the pipeline in reset while high.
REQ-013 SHALL have port done_ldr_o  out  1  image loaded and checksum correct.
REQ-014 SHALL have port err_ldr_o  out  1  load failed (length or checksum).

Function
REQ-015 A byte SHALL be accepted only in a cycle where byte_valid_ldr_i and byte_ready_ldr_o are both high.
REQ-016 Stream format SHALL be: 2-byte word count N (big-endian), N words of 4 bytes each (big-endian, MSB first), then 1 checksum byte.
REQ-017 Checksum SHALL equal the XOR of all 4N word bytes; the count bytes are excluded.
REQ-018 FSM states SHALL be IDLE, LEN_HI, LEN_LO, WORD, CHK, DONE, ERR.
REQ-019 IDLE/DONE/ERR SHALL move to LEN_HI on start_ldr_i, clearing the word counter, byte counter, address and checksum.
REQ-020 LEN_HI SHALL move to LEN_LO on an accepted byte, storing it as N[15:8].
REQ-021 LEN_LO SHALL store N[7:0] on an accepted byte; then go to ERR if N > IMEM_WORDS, to CHK if N == 0, else to WORD.
REQ-022 In WORD, a 2-bit byte counter SHALL shift accepted bytes into a 32-bit assembly register, MSB first.
REQ-023 On the 4th byte of a word, the next cycle SHALL drive wr_en_imem_ldr_o high for exactly 1 cycle, with wr_instr_imem_ldr_o = the assembled word and wr_addr_imem_ldr_o = BASE_ADDR + 4*word_index.
REQ-024 The word index SHALL then increment; after word N-1 the FSM SHALL go to CHK.
REQ-025 CHK SHALL go to DONE on an accepted byte equal to the running checksum, else to ERR.
REQ-026 byte_ready_ldr_o SHALL be high exactly in LEN_HI, LEN_LO, WORD and CHK.
REQ-027 Address arithmetic SHALL be 32-bit modulo 2^32; the word index SHALL be 16 bits wide.
REQ-028 cpu_reset_ldr_o SHALL be low only in DONE; done_ldr_o SHALL be high only in DONE; err_ldr_o SHALL be high only in ERR.
REQ-029 start_ldr_i asserted in LEN_HI..CHK SHALL restart the session (go to LEN_HI, counters cleared) and any byte offered in that cycle SHALL be discarded.
REQ-030 Idle cycles (byte_valid_ldr_i low) between bytes SHALL not affect state.

Reset
REQ-031 Reset SHALL asynchronously force IDLE, with byte_ready_ldr_o=0, wr_en_imem_ldr_o=0, wr_addr_imem_ldr_o=BASE_ADDR, wr_instr_imem_ldr_o=0, cpu_reset_ldr_o=1, done_ldr_o=0, err_ldr_o=0.
REQ-032 Reset asserted mid-session SHALL abandon the session; no write strobe SHALL issue afterwards.

Structure
REQ-033 FSM state encoding and the length/checksum field widths SHALL live in the shared pipeline package alongside the opcode defines.
REQ-034 The block SHALL be a single module with no sub-modules; the top-level wiring connects wr_en_imem_ldr_o/wr_instr_imem_ldr_o to the instruction memory write ports and ORs cpu_reset_ldr_o into the pipeline reset.

Verification
REQ-035 Scenario: start, bytes 00 01 12 34 56 78 08 -> one write, addr 0x0, data 0x12345678; then DONE, cpu_reset_ldr_o=0.
REQ-036 Scenario: N=2, words 0x20080005 and 0x00000000, checksum 0x2D -> writes at 0x0 and 0x4; DONE.
REQ-037 Scenario: same as REQ-035 but checksum byte 0x09 -> ERR, err_ldr_o=1, cpu_reset_ldr_o stays 1.
REQ-038 Scenario: IMEM_WORDS=1024, count bytes 04 01 -> ERR right after the 2nd byte; no write strobe.
REQ-039 Scenario: count 00 00 then checksum 00 -> DONE with no write; checksum 01 instead -> ERR.
REQ-040 Scenario: reset pulse after 2 word bytes, then a full REQ-035 session -> writes 0x12345678 to 0x0 only; random byte_valid_ldr_i gaps give an identical result.
